pic24_icsp_arbiter: RTL and testbench

- Shares one pic24flashprog command port between two requesters: requester 0 is the scripted imem/dmem sequencer; requester 1 is the host/debug command source.
- Arbitrates round-robin, with optional burst locking so an ICSP instruction sequence (for example TBLPAG setup followed by TBLRDL) cannot be interleaved.
- Tracks the owner of each outstanding read command (cmd=1) and routes each returned VISI word back to that requester.
- Sits between the requesters and pic24flashprog, in the pic24programmer top level.

---
 rtl/pic24_icsp_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_pic24_icsp_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic24_icsp_arbiter.sv
// Round-robin arbiter sharing one pic24flashprog command port between two requesters,
// with burst locking, lock timeout and in-order routing of returned VISI read data.
module pic24_icsp_arbiter #(
    parameter int unsigned TAGDEPTHlog2 = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned TOCNTW       = 11
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_cmd,
    input  logic [23:0] r0_instr,
    input  logic        r0_lock,
    output logic        r0_dvalid,
    output logic [15:0] r0_dout,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_cmd,
    input  logic [23:0] r1_instr,
    input  logic        r1_lock,
    output logic        r1_dvalid,
    output logic [15:0] r1_dout,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic        eng_cmd,
    output logic [23:0] eng_instr,
    input  logic        eng_dvalid,
    input  logic [15:0] eng_dout,
    output logic [1:0]  owner,
    output logic        timeout_err,
    output logic        orphan_err
);

    localparam int unsigned DEPTH = 1 << TAGDEPTHlog2;

    typedef enum logic [0:0] {StArb, StGrant} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              owner_q, owner_d;
    logic                    rr_last_q, rr_last_d;
    logic [TOCNTW-1:0]       to_cnt_q, to_cnt_d, to_cnt_inc;
    logic                    timeout_err_q, timeout_err_d;
    logic                    orphan_err_q;

    logic                    tags_q [DEPTH];
    logic [TAGDEPTHlog2-1:0] wptr_q, rptr_q;
    logic [TAGDEPTHlog2:0]   count_q;

    logic                    r0_dvalid_q, r1_dvalid_q;
    logic [15:0]             r0_dout_q, r1_dout_q;

    logic                    own_valid, own_cmd, own_lock, own_id;
    logic [23:0]             own_instr;
    logic                    tag_empty, tag_full, xfer, push, pop, head_tag;

    always_comb begin
        own_valid = 1'b0;
        own_cmd   = 1'b0;
        own_lock  = 1'b0;
        own_instr = '0;
        unique case (owner_q)
            2'b01: begin
                own_valid = r0_valid;
                own_cmd   = r0_cmd;
                own_lock  = r0_lock;
                own_instr = r0_instr;
            end
            2'b10: begin
                own_valid = r1_valid;
                own_cmd   = r1_cmd;
                own_lock  = r1_lock;
                own_instr = r1_instr;
            end
            default: ;
        endcase
    end

    assign own_id    = owner_q[1];
    assign tag_empty = (count_q == '0);
    // A pop in the same cycle frees a slot, so a stalled read can be taken then.
    assign tag_full  = (count_q == (TAGDEPTHlog2 + 1)'(DEPTH)) & ~eng_dvalid;

    assign eng_valid = (state_q == StGrant) & own_valid & ~(own_cmd & tag_full);
    assign eng_cmd   = eng_valid & own_cmd;
    assign eng_instr = eng_valid ? own_instr : '0;
    assign xfer      = eng_valid & eng_ready;
    assign r0_ready  = xfer & owner_q[0];
    assign r1_ready  = xfer & owner_q[1];

    // A return arriving while the FIFO is empty but a read is being pushed takes the new tag.
    assign push      = xfer & own_cmd;
    assign pop       = eng_dvalid & (~tag_empty | push);
    assign head_tag  = tag_empty ? own_id : tags_q[rptr_q];

    assign to_cnt_inc = to_cnt_q + TOCNTW'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        to_cnt_d      = '0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StArb: begin
                if (r0_valid & r1_valid) begin
                    owner_d = rr_last_q ? 2'b01 : 2'b10;
                end else if (r0_valid) begin
                    owner_d = 2'b01;
                end else if (r1_valid) begin
                    owner_d = 2'b10;
                end
                if (r0_valid | r1_valid) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (xfer) begin
                    if (!own_lock) begin
                        state_d   = StArb;
                        owner_d   = 2'b00;
                        rr_last_d = own_id;
                    end
                end else if (!own_valid) begin
                    if (!own_lock) begin
                        state_d   = StArb;
                        owner_d   = 2'b00;
                        rr_last_d = own_id;
                    end else if (to_cnt_inc == TOCNTW'(LOCK_TIMEOUT)) begin
                        state_d       = StArb;
                        owner_d       = 2'b00;
                        rr_last_d     = own_id;
                        timeout_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StArb;
            owner_q       <= 2'b00;
            rr_last_q     <= 1'b1;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tags_q[i] <= 1'b0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tags_q[wptr_q] <= own_id;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push & ~pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop & ~push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r0_dvalid_q  <= 1'b0;
            r1_dvalid_q  <= 1'b0;
            r0_dout_q    <= '0;
            r1_dout_q    <= '0;
            orphan_err_q <= 1'b0;
        end else begin
            r0_dvalid_q  <= pop & ~head_tag;
            r1_dvalid_q  <= pop & head_tag;
            orphan_err_q <= eng_dvalid & ~pop;
            if (pop & ~head_tag) begin
                r0_dout_q <= eng_dout;
            end
            if (pop & head_tag) begin
                r1_dout_q <= eng_dout;
            end
        end
    end

    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;
    assign orphan_err  = orphan_err_q;
    assign r0_dvalid   = r0_dvalid_q;
    assign r1_dvalid   = r1_dvalid_q;
    assign r0_dout     = r0_dout_q;
    assign r1_dout     = r1_dout_q;

endmodule

// File: tb/tb_pic24_icsp_arbiter.sv
// Directed bench for pic24_icsp_arbiter: a vector table for arbitration and read routing,
// plus hand sequences for FIFO-full stalls, lock timeout and reset mid-burst.
module tb_pic24_icsp_arbiter;

    localparam int unsigned LT = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        r0_valid, r0_ready, r0_cmd, r0_lock, r0_dvalid;
    logic [23:0] r0_instr;
    logic [15:0] r0_dout;
    logic        r1_valid, r1_ready, r1_cmd, r1_lock, r1_dvalid;
    logic [23:0] r1_instr;
    logic [15:0] r1_dout;
    logic        eng_valid, eng_ready, eng_cmd, eng_dvalid;
    logic [23:0] eng_instr;
    logic [15:0] eng_dout;
    logic [1:0]  owner;
    logic        timeout_err, orphan_err;

    pic24_icsp_arbiter #(
        .TAGDEPTHlog2(2),
        .LOCK_TIMEOUT(LT),
        .TOCNTW      (11)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_cmd     (r0_cmd),
        .r0_instr   (r0_instr),
        .r0_lock    (r0_lock),
        .r0_dvalid  (r0_dvalid),
        .r0_dout    (r0_dout),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_cmd     (r1_cmd),
        .r1_instr   (r1_instr),
        .r1_lock    (r1_lock),
        .r1_dvalid  (r1_dvalid),
        .r1_dout    (r1_dout),
        .eng_valid  (eng_valid),
        .eng_ready  (eng_ready),
        .eng_cmd    (eng_cmd),
        .eng_instr  (eng_instr),
        .eng_dvalid (eng_dvalid),
        .eng_dout   (eng_dout),
        .owner      (owner),
        .timeout_err(timeout_err),
        .orphan_err (orphan_err)
    );

    always #5 clk = ~clk;

    // i0/i1 = {valid, cmd, lock}; fl = {eng_valid, eng_cmd, r0_ready, r1_ready,
    // r0_dvalid, r1_dvalid, timeout_err, orphan_err}
    typedef struct {
        string       name;
        bit          rst;
        logic [2:0]  i0;
        logic [23:0] ins0;
        logic [2:0]  i1;
        logic [23:0] ins1;
        logic        er;
        logic        edv;
        logic [15:0] ed;
        logic [65:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mk(string n, bit rst, logic [2:0] i0, logic [23:0] ins0,
                                logic [2:0] i1, logic [23:0] ins1, logic er, logic edv,
                                logic [15:0] ed, logic [1:0] own, logic [7:0] fl,
                                logic [23:0] ei, logic [15:0] d0, logic [15:0] d1);
        vec_t v;
        v.name = n;  v.rst = rst;  v.i0 = i0;  v.ins0 = ins0;  v.i1 = i1;  v.ins1 = ins1;
        v.er = er;  v.edv = edv;  v.ed = ed;
        v.exp = {own, fl, ei, d0, d1};
        return v;
    endfunction

    function automatic logic [65:0] outs();
        return {owner, eng_valid, eng_cmd, r0_ready, r1_ready, r0_dvalid, r1_dvalid,
                timeout_err, orphan_err, eng_instr, r0_dout, r1_dout};
    endfunction

    task automatic chk(string nm, logic [65:0] act, logic [65:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_in(logic [2:0] i0, logic [23:0] ins0, logic [2:0] i1,
                          logic [23:0] ins1, logic er, logic edv, logic [15:0] ed);
        {r0_valid, r0_cmd, r0_lock} = i0;
        r0_instr = ins0;
        {r1_valid, r1_cmd, r1_lock} = i1;
        r1_instr = ins1;
        eng_ready  = er;
        eng_dvalid = edv;
        eng_dout   = ed;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int held;
        int early;
        bit done;

        // Single writer
        vecs.push_back(mk("rst0", 1, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("a_idle", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("a_arb", 0, 3'b100, 24'h040200, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("a_wait", 0, 3'b100, 24'h040200, 3'b000, '0, 1'b0, 1'b0, '0, 2'b01, 8'h80, 24'h040200, '0, '0));
        vecs.push_back(mk("a_xfer", 0, 3'b100, 24'h040200, 3'b000, '0, 1'b1, 1'b0, '0, 2'b01, 8'hA0, 24'h040200, '0, '0));
        vecs.push_back(mk("a_done", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        // Contention round-robin from reset
        vecs.push_back(mk("rst1", 1, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("b_arb0", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("b_r0a", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b01, 8'hA0, 24'h111111, '0, '0));
        vecs.push_back(mk("b_arb1", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("b_r1a", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b10, 8'h90, 24'h222222, '0, '0));
        vecs.push_back(mk("b_arb2", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("b_r0b", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b01, 8'hA0, 24'h111111, '0, '0));
        vecs.push_back(mk("b_arb3", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("b_r1b", 0, 3'b100, 24'h111111, 3'b100, 24'h222222, 1'b1, 1'b0, '0, 2'b10, 8'h90, 24'h222222, '0, '0));
        vecs.push_back(mk("b_idle", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        // Locked burst by r1 while r0 waits
        vecs.push_back(mk("c_arb", 0, 3'b000, '0, 3'b101, 24'h880190, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("c_b1", 0, 3'b100, 24'h333333, 3'b101, 24'h880190, 1'b1, 1'b0, '0, 2'b10, 8'h90, 24'h880190, '0, '0));
        vecs.push_back(mk("c_b2", 0, 3'b100, 24'h333333, 3'b101, 24'h207846, 1'b1, 1'b0, '0, 2'b10, 8'h90, 24'h207846, '0, '0));
        vecs.push_back(mk("c_b3", 0, 3'b100, 24'h333333, 3'b100, 24'hBA0BB6, 1'b1, 1'b0, '0, 2'b10, 8'h90, 24'hBA0BB6, '0, '0));
        vecs.push_back(mk("c_arb_r0", 0, 3'b100, 24'h333333, 3'b000, '0, 1'b1, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("c_r0", 0, 3'b100, 24'h333333, 3'b000, '0, 1'b0, 1'b0, '0, 2'b01, 8'h80, 24'h333333, '0, '0));
        vecs.push_back(mk("c_drop", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b01, 8'h00, '0, '0, '0));
        vecs.push_back(mk("c_idle", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        // Read routing and orphan return
        vecs.push_back(mk("d_arb0", 0, 3'b110, 24'h0A0A0A, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("d_rd0", 0, 3'b110, 24'h0A0A0A, 3'b000, '0, 1'b1, 1'b0, '0, 2'b01, 8'hE0, 24'h0A0A0A, '0, '0));
        vecs.push_back(mk("d_arb1", 0, 3'b000, '0, 3'b110, 24'h0B0B0B, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("d_rd1", 0, 3'b000, '0, 3'b110, 24'h0B0B0B, 1'b1, 1'b0, '0, 2'b10, 8'hD0, 24'h0B0B0B, '0, '0));
        vecs.push_back(mk("d_ret0", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 16'h1234, 2'b00, 8'h00, '0, '0, '0));
        vecs.push_back(mk("d_ret1", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 16'hFF00, 2'b00, 8'h08, '0, 16'h1234, '0));
        vecs.push_back(mk("d_out1", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h04, '0, 16'h1234, 16'hFF00));
        vecs.push_back(mk("d_hold", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, 16'h1234, 16'hFF00));
        vecs.push_back(mk("d_orph_in", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 16'hDEAD, 2'b00, 8'h00, '0, 16'h1234, 16'hFF00));
        vecs.push_back(mk("d_orph", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h01, '0, 16'h1234, 16'hFF00));
        vecs.push_back(mk("d_orph_end", 0, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, '0, 2'b00, 8'h00, '0, 16'h1234, 16'hFF00));

        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        cyc();
        foreach (vecs[i]) begin
            rstn = ~vecs[i].rst;
            set_in(vecs[i].i0, vecs[i].ins0, vecs[i].i1, vecs[i].ins1,
                   vecs[i].er, vecs[i].edv, vecs[i].ed);
            smp();
            chk(vecs[i].name, outs(), vecs[i].exp);
            cyc();
        end

        // Fill the tag FIFO with four locked reads, then stall, pass a write, pop-accept
        do_reset();
        set_in(3'b111, 24'h0C0C0C, '0, '0, 1'b1, 1'b0, '0);
        smp(); chk("full_arb_owner", 66'(owner), 66'(2'b00)); cyc();
        for (int k = 0; k < 4; k++) begin
            smp(); chk($sformatf("full_push%0d_ready", k), 66'(r0_ready), 66'(1'b1)); cyc();
        end
        smp(); chk("full_read_stall", 66'({eng_valid, r0_ready}), 66'(2'b00)); cyc();
        set_in(3'b101, 24'h0E0E0E, '0, '0, 1'b1, 1'b0, '0);
        smp();
        chk("full_write_pass", 66'({eng_valid, eng_cmd, r0_ready, eng_instr}),
            66'({1'b1, 1'b0, 1'b1, 24'h0E0E0E}));
        cyc();
        set_in(3'b111, 24'h0C0C0C, '0, '0, 1'b1, 1'b0, '0);
        smp(); chk("full_read_stall2", 66'(eng_valid), 66'(1'b0)); cyc();
        set_in(3'b111, 24'h0C0C0C, '0, '0, 1'b1, 1'b1, 16'h5555);
        smp(); chk("full_pop_accept", 66'({eng_valid, r0_ready}), 66'(2'b11)); cyc();
        set_in(3'b111, 24'h0C0C0C, '0, '0, 1'b1, 1'b0, '0);
        smp();
        chk("full_after_pop", 66'({eng_valid, r0_dvalid, r0_dout}), 66'({1'b0, 1'b1, 16'h5555}));
        cyc();
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        smp(); cyc();
        for (int k = 0; k < 4; k++) begin
            set_in('0, '0, '0, '0, 1'b0, 1'b1, 16'(16'hA000 + k));
            smp(); cyc();
            set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
            smp();
            chk($sformatf("drain%0d", k), 66'({r0_dvalid, r1_dvalid, orphan_err, r0_dout}),
                66'({3'b100, 16'(16'hA000 + k)}));
            cyc();
        end
        set_in('0, '0, '0, '0, 1'b0, 1'b1, 16'hBEEF);
        smp(); cyc();
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        smp();
        chk("drained_orphan", 66'({orphan_err, r0_dvalid, r1_dvalid, r0_dout}),
            66'({3'b100, 16'hA003}));
        cyc();

        // Lock timeout: r1 holds the grant with lock=1 and no valid
        do_reset();
        set_in('0, '0, 3'b101, '0, 1'b0, 1'b0, '0);
        smp(); cyc();
        set_in('0, '0, 3'b001, '0, 1'b0, 1'b0, '0);
        held  = 0;
        early = 0;
        done  = 1'b0;
        while (!done && held < 2 * int'(LT)) begin
            smp();
            if (owner == 2'b10) begin
                held++;
                if (timeout_err) early++;
                cyc();
            end else begin
                done = 1'b1;
            end
        end
        chk("to_held_cycles", 66'(held), 66'(LT));
        chk("to_no_early", 66'(early), 66'(0));
        chk("to_release", 66'({owner, timeout_err}), 66'(3'b001));
        cyc();
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        smp(); chk("to_pulse_one", 66'(timeout_err), 66'(1'b0)); cyc();

        // Reset while r0 holds a locked burst with two reads outstanding
        do_reset();
        set_in(3'b111, 24'h0D0D0D, '0, '0, 1'b1, 1'b0, '0);
        smp(); cyc();
        smp(); cyc();
        smp(); chk("mid_owner", 66'(owner), 66'(2'b01)); cyc();
        rstn = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), '0);
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        cyc();
        rstn = 1'b1;
        smp(); chk("mid_after_reset", outs(), '0); cyc();
        set_in('0, '0, '0, '0, 1'b0, 1'b1, 16'h7777);
        smp(); cyc();
        set_in('0, '0, '0, '0, 1'b0, 1'b0, '0);
        smp();
        chk("mid_orphan", 66'({orphan_err, r0_dvalid, r1_dvalid, r0_dout}),
            66'({3'b100, 16'h0000}));
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
